// File: rtl/alert_pkg.sv
// Shared types and helpers for the alert_gen frame-strobe generator.
// Holds the channel window config, the window-hit compare and the reset constants.
package alert_pkg;

    // Widest frame position supported; channels zero-extend their CNT_W fields into this.
    localparam int POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] offset;
        logic [POS_W-1:0] width;
    } win_cfg_t;

    localparam win_cfg_t CFG_RST         = '0;
    localparam logic     RST_STROBE      = 1'b0;
    localparam logic     RST_FRAME_START = 1'b0;
    localparam logic     RST_BUSY        = 1'b0;

    // End of window is formed one bit wider so offset+width never wraps.
    function automatic logic win_hit(input win_cfg_t cfg, input logic [POS_W-1:0] pos);
        logic [POS_W:0] win_end;
        win_end = {1'b0, cfg.offset} + {1'b0, cfg.width};
        return (pos >= cfg.offset) && ({1'b0, pos} < win_end);
    endfunction

endpackage

// File: rtl/alert_window.sv
// One strobe channel: shadow/active window config plus registered window compare.
// Latency: strobe is registered from next_count, so it aligns with count; no backpressure.
module alert_window
    import alert_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_offset,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             xfer,
    input  logic [CNT_W-1:0] next_count,
    output logic             strobe
);

    win_cfg_t shadow_cfg;
    win_cfg_t active_cfg;
    win_cfg_t active_next;
    win_cfg_t load_cfg;

    always_comb begin
        load_cfg        = CFG_RST;
        load_cfg.offset = POS_W'(cfg_offset);
        load_cfg.width  = POS_W'(cfg_width);
        active_next     = xfer ? shadow_cfg : active_cfg;
    end

    // Transfer reads the shadow before this edge's load overwrites it.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            shadow_cfg <= CFG_RST;
            active_cfg <= CFG_RST;
            strobe     <= RST_STROBE;
        end else begin
            if (cfg_load) begin
                shadow_cfg <= load_cfg;
            end
            active_cfg <= active_next;
            strobe     <= win_hit(active_next, POS_W'(next_count));
        end
    end

endmodule

// File: rtl/alert_gen.sv
// Frame counter with NUM_CH programmable strobe windows; ALERT_EXT_SYNC_EN adds an ext_sync input.
// Latency: count/strobe/frame_start registered from one next-count; config applies at a boundary; no backpressure.
module alert_gen
    import alert_pkg::*;
#(
    parameter  int FRAME_LEN = 256,
    parameter  int NUM_CH    = 2,
    localparam int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [NUM_CH*CNT_W-1:0] cfg_offset,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    input  logic                    cfg_load,
    output logic                    cfg_busy,
    output logic [CNT_W-1:0]        count,
    output logic                    frame_start,
    output logic [NUM_CH-1:0]       strobe
`ifdef ALERT_EXT_SYNC_EN
    ,
    input  logic                    ext_sync
`endif
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);

    logic             sync;
    logic             wrap;
    logic             boundary;
    logic             xfer;
    logic [CNT_W-1:0] next_count;

`ifdef ALERT_EXT_SYNC_EN
    assign sync = ext_sync;
`else
    assign sync = 1'b0;
`endif

    // A sync landing on the last position coincides with the wrap: still one boundary.
    always_comb begin
        wrap     = run && (count == LAST_POS);
        boundary = sync || wrap;
        xfer     = cfg_busy && (boundary || !run);
        if (boundary) begin
            next_count = '0;
        end else if (run) begin
            next_count = count + CNT_W'(1);
        end else begin
            next_count = count;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            frame_start <= RST_FRAME_START;
            cfg_busy    <= RST_BUSY;
        end else begin
            count       <= next_count;
            frame_start <= boundary;
            if (cfg_load) begin
                cfg_busy <= 1'b1;
            end else if (xfer) begin
                cfg_busy <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        alert_window #(
            .CNT_W(CNT_W)
        ) u_win (
            .sysclk     (sysclk),
            .reset      (reset),
            .cfg_load   (cfg_load),
            .cfg_offset (cfg_offset[i*CNT_W +: CNT_W]),
            .cfg_width  (cfg_width[i*CNT_W +: CNT_W]),
            .xfer       (xfer),
            .next_count (next_count),
            .strobe     (strobe[i])
        );
    end

endmodule

// File: tb/tb_alert_gen.sv
// Directed bench for alert_gen at FRAME_LEN=256, NUM_CH=2; ext_sync cases need ALERT_EXT_SYNC_EN.
module tb_alert_gen;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] cfg_offset;
    logic [15:0] cfg_width;
    logic        cfg_load;
    logic        cfg_busy;
    logic [7:0]  count;
    logic        frame_start;
    logic [1:0]  strobe;
`ifdef ALERT_EXT_SYNC_EN
    logic        ext_sync;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sysclk = ~sysclk;

    alert_gen #(
        .FRAME_LEN(256),
        .NUM_CH   (2)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .run         (run),
        .cfg_offset  (cfg_offset),
        .cfg_width   (cfg_width),
        .cfg_load    (cfg_load),
        .cfg_busy    (cfg_busy),
        .count       (count),
        .frame_start (frame_start),
        .strobe      (strobe)
`ifdef ALERT_EXT_SYNC_EN
        ,
        .ext_sync    (ext_sync)
`endif
    );

    typedef struct {
        logic       run;
        logic       load;
        logic [7:0] o0, w0, o1, w1;
        logic [7:0] count;
        logic [1:0] strobe;
        logic       fs;
        logic       busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at negedge; one posedge later, outputs are sampled at the next negedge.
    task automatic step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic adv(input int n);
        run      = 1'b1;
        cfg_load = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_step(input logic r, input logic [7:0] o0, w0, o1, w1);
        run        = r;
        cfg_load   = 1'b1;
        cfg_offset = {o1, o0};
        cfg_width  = {w1, w0};
        step();
        cfg_load   = 1'b0;
    endtask

    task automatic at(input string name, input logic [7:0] c, input logic [1:0] s);
        chk({name, "_count"}, 32'(count), 32'(c));
        chk({name, "_strobe"}, 32'(strobe), 32'(s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int any_strobe;
        vecs[0]  = '{1'b0, 1'b1, 8'd128, 8'd1, 8'd144, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd1, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd2, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'd2,   8'd3, 8'd0,   8'd0, 8'd2, 2'b00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd2, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd3, 2'b01, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd4, 2'b01, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd5, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'd5,   8'd1, 8'd0,   8'd0, 8'd5, 2'b00, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'd128, 8'd1, 8'd144, 8'd1, 8'd5, 2'b01, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'd0,   8'd0, 8'd0,   8'd0, 8'd5, 2'b00, 1'b0, 1'b0};

        reset      = 1'b0;
        run        = 1'b0;
        cfg_load   = 1'b0;
        cfg_offset = '0;
        cfg_width  = '0;
`ifdef ALERT_EXT_SYNC_EN
        ext_sync   = 1'b0;
`endif
        @(negedge sysclk);
        @(negedge sysclk);
        at("rst", 8'd0, 2'b00);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        reset = 1'b1;
        @(negedge sysclk);

        // Stopped loads, back-to-back loads and early windows from the table.
        for (int i = 0; i < 12; i++) begin
            run        = vecs[i].run;
            cfg_load   = vecs[i].load;
            cfg_offset = {vecs[i].o1, vecs[i].o0};
            cfg_width  = {vecs[i].w1, vecs[i].w0};
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].count));
            chk($sformatf("vec%0d_strobe", i), 32'(strobe), 32'(vecs[i].strobe));
            chk($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
            chk($sformatf("vec%0d_busy", i), 32'(cfg_busy), 32'(vecs[i].busy));
        end
        cfg_load = 1'b0;

        // Single-cycle windows at 128 and 144, then the wrap pulse.
        adv(122); at("p1_127", 8'd127, 2'b00);
        adv(1);   at("p1_128", 8'd128, 2'b01);
        adv(1);   at("p1_129", 8'd129, 2'b00);
        adv(15);  at("p1_144", 8'd144, 2'b10);
        adv(1);   at("p1_145", 8'd145, 2'b00);
        adv(110); chk("p1_255_fs", 32'(frame_start), 32'd0);
        adv(1);   at("p1_wrap", 8'd0, 2'b00);
        chk("p1_wrap_fs", 32'(frame_start), 32'd1);
        adv(1);   chk("p1_fs_drop", 32'(frame_start), 32'd0);

        // Load mid-frame: old window still fires, new one next frame.
        adv(49);
        load_step(1'b1, 8'd10, 8'd4, 8'd144, 8'd1);
        at("p2_51", 8'd51, 2'b00);
        chk("p2_busy_51", 32'(cfg_busy), 32'd1);
        adv(77);  at("p2_old128", 8'd128, 2'b01);
        chk("p2_busy_128", 32'(cfg_busy), 32'd1);
        adv(127); chk("p2_busy_255", 32'(cfg_busy), 32'd1);
        adv(1);   at("p2_wrap", 8'd0, 2'b00);
        chk("p2_busy_wrap", 32'(cfg_busy), 32'd0);
        chk("p2_fs_wrap", 32'(frame_start), 32'd1);
        adv(10);  at("p2_10", 8'd10, 2'b01);
        adv(3);   at("p2_13", 8'd13, 2'b01);
        adv(1);   at("p2_14", 8'd14, 2'b00);
        adv(114); at("p2_new128", 8'd128, 2'b00);

        // Window running past the frame end is truncated.
        load_step(1'b1, 8'd10, 8'd4, 8'd250, 8'd10);
        adv(126); at("p3_255_old", 8'd255, 2'b00);
        adv(1);   chk("p3_busy_wrap", 32'(cfg_busy), 32'd0);
        adv(249); at("p3_249", 8'd249, 2'b00);
        adv(1);   at("p3_250", 8'd250, 2'b10);
        adv(5);   at("p3_255", 8'd255, 2'b10);
        adv(1);   at("p3_0", 8'd0, 2'b00);

        // Hold inside a window with run low.
        load_step(1'b1, 8'd98, 8'd8, 8'd250, 8'd10);
        adv(254);
        adv(1);   chk("p4_busy_wrap", 32'(cfg_busy), 32'd0);
        adv(100); at("p4_100", 8'd100, 2'b01);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            at($sformatf("p4_hold%0d", k), 8'd100, 2'b01);
            chk($sformatf("p4_hold%0d_fs", k), 32'(frame_start), 32'd0);
        end
        adv(1);   at("p4_resume", 8'd101, 2'b01);

        // Reset mid-window with a load pending.
        load_step(1'b1, 8'd0, 8'd1, 8'd1, 8'd1);
        chk("p5_pending", 32'(cfg_busy), 32'd1);
        reset = 1'b0;
        #1;
        at("p5_async", 8'd0, 2'b00);
        chk("p5_async_fs", 32'(frame_start), 32'd0);
        chk("p5_async_busy", 32'(cfg_busy), 32'd0);
        @(negedge sysclk);
        reset = 1'b1;
        any_strobe = 0;
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            step();
            if (strobe != 2'b00 || cfg_busy) any_strobe++;
        end
        chk("p5_no_strobe", 32'(any_strobe), 32'd0);
        chk("p5_count", 32'(count), 32'd44);

`ifdef ALERT_EXT_SYNC_EN
        // ext_sync acts as a boundary and applies the pending config.
        load_step(1'b1, 8'd0, 8'd2, 8'd77, 8'd1);
        adv(32);  at("p6_77", 8'd77, 2'b00);
        ext_sync = 1'b1;
        step();
        ext_sync = 1'b0;
        at("p6_sync", 8'd0, 2'b01);
        chk("p6_sync_fs", 32'(frame_start), 32'd1);
        chk("p6_sync_busy", 32'(cfg_busy), 32'd0);
        step();
        at("p6_after", 8'd1, 2'b01);
        chk("p6_after_fs", 32'(frame_start), 32'd0);
        adv(254);
        ext_sync = 1'b1;
        step();
        ext_sync = 1'b0;
        at("p6_last_sync", 8'd0, 2'b01);
        chk("p6_last_fs", 32'(frame_start), 32'd1);
        step();
        at("p6_single", 8'd1, 2'b01);
        chk("p6_single_fs", 32'(frame_start), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
